// File: rtl/iserdes_deser_n.sv
// Multi-channel SDR deserializer with internal word framing, bitslip alignment,
// clock-enable gating and a framing-phase readout. All channels share one framer.
module iserdes_deser_n #(
  parameter int NCH            = 1,
  parameter int DATA_WIDTH     = 4,
  parameter int BITSLIP_ENABLE = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      CE,
  input  logic [NCH-1:0]            D,
  input  logic                      BITSLIP,
  output logic [NCH*DATA_WIDTH-1:0] Q,
  output logic                      VALID,
  output logic [2:0]                PHASE,
  output logic                      SLIP_ACK,
  output logic [NCH-1:0]            SHIFTOUT
);

  localparam int                CNT_W      = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DATA_WIDTH - 1);
  localparam logic [2:0]        PHASE_LAST = 3'(DATA_WIDTH - 1);

  logic [NCH-1:0][DATA_WIDTH-1:0] sr_q, sr_d;
  logic [NCH-1:0][DATA_WIDTH-1:0] q_q, q_d;
  logic [NCH-1:0]                 so_q, so_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [2:0]                     phase_q, phase_d;
  logic                           valid_q, valid_d;
  logic                           slip_ack_q, slip_ack_d;
  logic                           slip_pending_q, slip_pending_d;
  logic                           bs_prev_q, bs_prev_d;

  logic slip_req;
  logic slip_now;
  logic word_end;

  always_comb begin
    slip_req = (BITSLIP_ENABLE != 0) && BITSLIP && !bs_prev_q;
    // A request on a CE edge is applied on that same edge.
    slip_now = CE && (slip_pending_q || slip_req);
    word_end = CE && !slip_now && (cnt_q == CNT_LAST);

    sr_d           = sr_q;
    q_d            = q_q;
    so_d           = so_q;
    cnt_d          = cnt_q;
    phase_d        = phase_q;
    bs_prev_d      = BITSLIP;
    valid_d        = word_end;
    slip_ack_d     = slip_now;
    slip_pending_d = slip_pending_q;

    if (slip_now) begin
      slip_pending_d = 1'b0;
    end else if (slip_req) begin
      slip_pending_d = 1'b1;
    end

    if (CE) begin
      for (int ch = 0; ch < NCH; ch++) begin
        sr_d[ch] = {D[ch], sr_q[ch][DATA_WIDTH-1:1]};
        so_d[ch] = sr_q[ch][0];
      end
      // A slip swallows one count so the next word spans one extra bit.
      if (slip_now) begin
        phase_d = (phase_q == PHASE_LAST) ? 3'd0 : phase_q + 3'd1;
      end else begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
    end

    if (word_end) begin
      q_d = sr_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sr_q           <= '0;
      q_q            <= '0;
      so_q           <= '0;
      cnt_q          <= '0;
      phase_q        <= '0;
      valid_q        <= 1'b0;
      slip_ack_q     <= 1'b0;
      slip_pending_q <= 1'b0;
      bs_prev_q      <= 1'b0;
    end else begin
      sr_q           <= sr_d;
      q_q            <= q_d;
      so_q           <= so_d;
      cnt_q          <= cnt_d;
      phase_q        <= phase_d;
      valid_q        <= valid_d;
      slip_ack_q     <= slip_ack_d;
      slip_pending_q <= slip_pending_d;
      bs_prev_q      <= bs_prev_d;
    end
  end

  assign Q        = q_q;
  assign VALID    = valid_q;
  assign PHASE    = (BITSLIP_ENABLE != 0) ? phase_q : 3'd0;
  assign SLIP_ACK = slip_ack_q;
  assign SHIFTOUT = so_q;

endmodule

// File: tb/tb_iserdes_deser_n.sv
// Scoreboard bench for iserdes_deser_n (NCH=2, DATA_WIDTH=4): a bit-history
// reference predicts each word, VALID, PHASE, SLIP_ACK and SHIFTOUT per edge.
module tb_iserdes_deser_n;

  logic       CLK;
  logic       RST_N;
  logic       CE;
  logic [1:0] D;
  logic       BITSLIP;
  logic [7:0] Q;
  logic       VALID;
  logic [2:0] PHASE;
  logic       SLIP_ACK;
  logic [1:0] SHIFTOUT;

  iserdes_deser_n #(
    .NCH(2),
    .DATA_WIDTH(4),
    .BITSLIP_ENABLE(1)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .CE(CE),
    .D(D),
    .BITSLIP(BITSLIP),
    .Q(Q),
    .VALID(VALID),
    .PHASE(PHASE),
    .SLIP_ACK(SLIP_ACK),
    .SHIFTOUT(SHIFTOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference state: full sampled-bit history per edge, framing count, slip state.
  logic [1:0] hist[$];
  logic [7:0] sb[$];
  int         m_cnt;
  int         m_phase;
  bit         m_pend;
  bit         m_prev;
  logic [1:0] m_so;
  logic [7:0] m_qhold;
  bit         e_valid;
  bit         e_ack;

  task automatic model_reset();
    hist.delete();
    sb.delete();
    m_cnt   = 0;
    m_phase = 0;
    m_pend  = 0;
    m_prev  = 0;
    m_so    = 2'b00;
    m_qhold = 8'h00;
    e_valid = 0;
    e_ack   = 0;
  endtask

  task automatic model_edge(input logic ce, input logic [1:0] d, input logic bs);
    bit req;
    bit slip;
    logic [7:0] w;
    int n;
    req    = bs && !m_prev;
    m_prev = bs;
    slip   = ce && (m_pend || req);
    if (slip) m_pend = 0;
    else if (req) m_pend = 1;
    e_valid = 0;
    e_ack   = slip;
    if (ce) begin
      n    = hist.size();
      m_so = (n >= 4) ? hist[n-4] : 2'b00;
      hist.push_back(d);
      if (slip) begin
        m_phase = (m_phase + 1) % 4;
      end else if (m_cnt == 3) begin
        m_cnt = 0;
        n = hist.size();
        for (int i = 0; i < 4; i++) begin
          w[i]   = hist[n-4+i][0];
          w[4+i] = hist[n-4+i][1];
        end
        sb.push_back(w);
        e_valid = 1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // Called at a falling edge; drives inputs, predicts, checks after the rising edge.
  task automatic step(input logic ce, input logic [1:0] d, input logic bs);
    CE      = ce;
    D       = d;
    BITSLIP = bs;
    model_edge(ce, d, bs);
    @(posedge CLK);
    #1;
    check("valid", VALID, e_valid);
    if (VALID) begin
      check("sb_avail", sb.size() > 0, 1);
      if (sb.size() > 0) m_qhold = sb.pop_front();
    end
    check("q", Q, m_qhold);
    check("phase", PHASE, m_phase);
    check("slip_ack", SLIP_ACK, e_ack);
    check("shiftout", SHIFTOUT, m_so);
    @(negedge CLK);
  endtask

  task automatic async_reset();
    #2;
    RST_N   = 1'b0;
    BITSLIP = 1'b0;
    CE      = 1'b0;
    #1;
    check("rst_q", Q, 0);
    check("rst_valid", VALID, 0);
    check("rst_phase", PHASE, 0);
    check("rst_ack", SLIP_ACK, 0);
    check("rst_so", SHIFTOUT, 0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  function automatic logic [1:0] rnd();
    logic [1:0] r;
    r = 2'($urandom_range(0, 3));
    return r;
  endfunction

  logic [1:0] basic_bits[4] = '{2'b01, 2'b00, 2'b11, 2'b01};
  logic [1:0] post_bits[4]  = '{2'b10, 2'b11, 2'b01, 2'b10};

  initial begin
    int pat;
    RST_N   = 1'b1;
    CE      = 1'b0;
    D       = 2'b00;
    BITSLIP = 1'b0;
    model_reset();
    async_reset();

    // Idle with CE low: nothing may move.
    for (int i = 0; i < 10; i++) step(1'b0, rnd(), 1'b0);

    // Basic capture.
    for (int i = 0; i < 4; i++) step(1'b1, basic_bits[i], 1'b0);
    check("basic_q", Q, 8'h4D);
    check("basic_valid", VALID, 1);
    step(1'b1, rnd(), 1'b0);
    check("so_edge5", SHIFTOUT[0], 1);
    for (int i = 0; i < 11; i++) step(1'b1, rnd(), 1'b0);

    // CE gaps inside a word.
    for (int r = 0; r < 2; r++) begin
      step(1'b1, rnd(), 1'b0);
      step(1'b1, rnd(), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, rnd(), 1'b0);
      step(1'b1, rnd(), 1'b0);
      step(1'b1, rnd(), 1'b0);
    end

    // Single slip on a repeating 1000 pattern.
    pat = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, (pat % 4 == 0) ? 2'b11 : 2'b00, 1'b0);
      pat++;
    end
    step(1'b1, (pat % 4 == 0) ? 2'b11 : 2'b00, 1'b1);
    pat++;
    check("phase_one", PHASE, 1);
    check("ack_one", SLIP_ACK, 1);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, (pat % 4 == 0) ? 2'b11 : 2'b00, 1'b0);
      pat++;
    end

    // Four separated slips wrap the phase.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, rnd(), 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, rnd(), 1'b0);
    end
    check("phase_wrap", PHASE, 1);

    // BITSLIP held high yields one slip.
    for (int i = 0; i < 20; i++) step(1'b1, rnd(), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, rnd(), 1'b0);
    check("phase_held", PHASE, 2);

    // Second rising edge while pending under CE low.
    step(1'b0, rnd(), 1'b1);
    step(1'b0, rnd(), 1'b0);
    step(1'b0, rnd(), 1'b1);
    step(1'b0, rnd(), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, rnd(), 1'b0);
    check("phase_pend", PHASE, 3);

    // Slip coinciding with the word-end edge.
    for (int g = 0; g < 8 && m_cnt != 3; g++) step(1'b1, rnd(), 1'b0);
    step(1'b1, rnd(), 1'b1);
    check("coinc_novalid", VALID, 0);
    step(1'b1, rnd(), 1'b0);
    check("coinc_valid", VALID, 1);
    for (int i = 0; i < 4; i++) step(1'b1, rnd(), 1'b0);

    // Reset mid-word with a slip pending.
    step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    step(1'b0, rnd(), 1'b1);
    async_reset();
    for (int i = 0; i < 4; i++) step(1'b1, post_bits[i], 1'b0);
    check("post_rst_q", Q, 8'hB6);
    check("post_rst_valid", VALID, 1);
    check("post_rst_phase", PHASE, 0);
    for (int i = 0; i < 8; i++) step(1'b1, rnd(), 1'b0);

    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
